// File: rtl/imem_responder.sv
// Instruction-memory responder: one word read in flight, fixed LATENCY, response held until taken.
// Optional build macro IMEM_ALIGN_CHECK_EN flags misaligned reads and drops misaligned loads.
module imem_responder #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 64,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 2**(ADDR_W-2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;
    localparam int         IDX_W    = ADDR_W - 2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_rsp_data;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [IDX_W-1:0]  w_req_idx;
    logic [IDX_W-1:0]  w_ld_idx;
    logic [IDX_W-1:0]  w_rd_idx;
    logic              w_accept;
    logic              w_rd_fire;
    logic              w_rd_mis;
    logic              w_ld_we;

    assign w_req_idx = req_addr[ADDR_W-1:2];
    assign w_ld_idx  = ld_addr[ADDR_W-1:2];
    assign w_accept  = (r_state == S_IDLE) && req_valid;
    // The array is sampled on the edge that enters RESP: the accept edge itself when LATENCY is 1.
    assign w_rd_fire = (LATENCY == 1) ? w_accept : ((r_state == S_WAIT) && (r_cnt == 4'd1));
    assign w_rd_idx  = (r_state == S_IDLE) ? w_req_idx : r_idx;

`ifdef IMEM_ALIGN_CHECK_EN
    logic r_mis;
    logic r_rsp_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mis     <= 1'b0;
            r_rsp_err <= 1'b0;
        end else begin
            if (w_accept) r_mis <= |req_addr[1:0];
            if (w_rd_fire) r_rsp_err <= w_rd_mis;
        end
    end

    assign w_rd_mis = (r_state == S_IDLE) ? |req_addr[1:0] : r_mis;
    assign w_ld_we  = ld_en && (ld_addr[1:0] == 2'b00);
    assign rsp_err  = r_rsp_err;
`else
    assign w_rd_mis = 1'b0;
    assign w_ld_we  = ld_en;
    // Low address bits play no part here; the AND keeps rsp_err at 0 while still consuming them.
    assign rsp_err  = &{1'b0, req_addr[1:0], ld_addr[1:0]};
`endif

    always_ff @(posedge clk) begin
        if (w_ld_we) r_mem[w_ld_idx] <= ld_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_idx      <= '0;
            r_rsp_data <= '0;
        end else begin
            if (w_rd_fire) r_rsp_data <= w_rd_mis ? '0 : r_mem[w_rd_idx];
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_idx   <= w_req_idx;
                        r_cnt   <= CNT_INIT;
                        r_state <= (LATENCY > 1) ? S_WAIT : S_RESP;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) r_state <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_data  = r_rsp_data;
endmodule
